sha256_msg_feeder: RTL and testbench

Initiator for the SHA-256 compression core's block handshake. Accepts a message as a byte stream and applies FIPS 180-4 padding: a 0x80 byte, zero bytes, then the 64-bit big-endian bit length. It assembles 512-bit blocks, issues each block to the core with the start/done handshake, and chains the core's results. It returns the final 256-bit digest to the upstream user.

---
 rtl/sha256_msg_feeder.sv | 180 ++++++++++++++++++
 tb/tb_sha256_msg_feeder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_feeder.sv
// SHA-256 message feeder: pads a byte stream into 512-bit blocks, drives the
// compression core through a start/done handshake and chains its results.
module sha256_msg_feeder #(
    parameter int          LEN_W = 32,
    parameter logic [255:0] IV   = 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         msg_valid,
    input  logic [7:0]   msg_data,
    input  logic         msg_last,
    output logic         msg_ready,
    output logic [511:0] blk_w,
    output logic         start_out,
    input  logic         done_in,
    input  logic [255:0] result_in,
    output logic [255:0] chain_out,
    output logic [255:0] digest,
    output logic         digest_valid
);

    typedef enum logic [2:0] {IDLE, FILL, PAD, LEN, ISSUE, RELEASE, OUT} state_t;

    state_t             state_q, state_d;
    state_t             nxt_q, nxt_d;
    logic [5:0]         pos_q, pos_d;
    logic [LEN_W-1:0]   nbytes_q, nbytes_d;
    logic               pad80_q, pad80_d;
    logic [511:0]       blk_q, blk_d;
    logic [255:0]       chain_q, chain_d;
    logic [255:0]       digest_q, digest_d;
    logic               digest_valid_q, digest_valid_d;
    logic               msg_ready_q, msg_ready_d;
    logic               start_q, start_d;

    logic               accept;
    logic               wr_en;
    logic [7:0]         wr_byte;
    logic               blk_clr;
    logic [511:0]       blk_base;
    logic [63:0]        len_bits;
    logic [63:0]        len_shift;

    assign accept    = msg_valid & msg_ready_q;
    assign len_bits  = 64'({nbytes_q, 3'b000});
    // Length bytes 56..63 map to big-endian bytes 7..0 of len_bits.
    assign len_shift = len_bits >> {~pos_q[2:0], 3'b000};
    assign blk_base  = blk_clr ? 512'd0 : blk_q;

    // One write lane per byte position; only the addressed lane changes.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_lane
            assign blk_d[511 - 8*gi -: 8] = (wr_en && (pos_q == 6'(gi))) ? wr_byte
                                                                        : blk_base[511 - 8*gi -: 8];
        end
    endgenerate

    always_comb begin
        state_d        = state_q;
        nxt_d          = nxt_q;
        pos_d          = pos_q;
        nbytes_d       = nbytes_q;
        pad80_d        = pad80_q;
        chain_d        = chain_q;
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;
        wr_en          = 1'b0;
        wr_byte        = msg_data;
        blk_clr        = 1'b0;

        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    wr_en = 1'b1;
                    pos_d = pos_q + 6'd1;
                    if (state_q == IDLE) begin
                        digest_valid_d = 1'b0;
                        chain_d        = IV;
                        blk_clr        = 1'b1;
                        nbytes_d       = LEN_W'(1);
                    end else begin
                        nbytes_d = nbytes_q + LEN_W'(1);
                    end
                    if (pos_q == 6'd63) begin
                        state_d = ISSUE;
                        nxt_d   = msg_last ? PAD : FILL;
                        pad80_d = msg_last;
                    end else if (msg_last) begin
                        state_d = PAD;
                        pad80_d = 1'b1;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            PAD: begin
                if (pos_q == 6'd56 && !pad80_q) begin
                    state_d = LEN;
                end else begin
                    wr_en   = 1'b1;
                    wr_byte = pad80_q ? 8'h80 : 8'h00;
                    pad80_d = 1'b0;
                    pos_d   = pos_q + 6'd1;
                    if (pos_q == 6'd63) begin
                        state_d = ISSUE;
                        nxt_d   = PAD;
                    end
                end
            end
            LEN: begin
                wr_en   = 1'b1;
                wr_byte = len_shift[7:0];
                pos_d   = pos_q + 6'd1;
                if (pos_q == 6'd63) begin
                    state_d = ISSUE;
                    nxt_d   = OUT;
                end
            end
            ISSUE: begin
                if (done_in) begin
                    chain_d = result_in;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // The core must drop done before the next block may start.
                if (!done_in) begin
                    pos_d   = 6'd0;
                    blk_clr = 1'b1;
                    state_d = nxt_q;
                end
            end
            OUT: begin
                digest_d       = chain_q;
                digest_valid_d = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase

        msg_ready_d = (state_d == IDLE) || (state_d == FILL);
        start_d     = (state_d == ISSUE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            nxt_q          <= IDLE;
            pos_q          <= 6'd0;
            nbytes_q       <= '0;
            pad80_q        <= 1'b0;
            blk_q          <= 512'd0;
            chain_q        <= IV;
            digest_q       <= 256'd0;
            digest_valid_q <= 1'b0;
            msg_ready_q    <= 1'b0;
            start_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            nxt_q          <= nxt_d;
            pos_q          <= pos_d;
            nbytes_q       <= nbytes_d;
            pad80_q        <= pad80_d;
            blk_q          <= blk_d;
            chain_q        <= chain_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            msg_ready_q    <= msg_ready_d;
            start_q        <= start_d;
        end
    end

    assign msg_ready    = msg_ready_q;
    assign blk_w        = blk_q;
    assign start_out    = start_q;
    assign chain_out    = chain_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: behavioural SHA-256 core on the handshake,
// scoreboards of expected blocks/chains and digests.
module tb_sha256_msg_feeder;

    localparam logic [255:0] IV      = 256'h6A09E667_BB67AE85_3C6EF372_A54FF53A_510E527F_9B05688C_1F83D9AB_5BE0CD19;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D56_DIG = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk;
    logic         reset;
    logic         msg_valid;
    logic [7:0]   msg_data;
    logic         msg_last;
    logic         msg_ready;
    logic [511:0] blk_w;
    logic         start_out;
    logic         done_in;
    logic [255:0] result_in;
    logic [255:0] chain_out;
    logic [255:0] digest;
    logic         digest_valid;

    sha256_msg_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .msg_valid    (msg_valid),
        .msg_data     (msg_data),
        .msg_last     (msg_last),
        .msg_ready    (msg_ready),
        .blk_w        (blk_w),
        .start_out    (start_out),
        .done_in      (done_in),
        .result_in    (result_in),
        .chain_out    (chain_out),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] blk;
        logic [255:0] chain;
    } blk_exp_t;

    blk_exp_t     exp_blk_q[$];
    logic [255:0] exp_dig_q[$];
    logic [7:0]   cur_msg[$];
    int           checks = 0;
    int           failures = 0;
    int           extra_hold = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, hh} = h;
        for (int t = 0; t < 64; t++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    task automatic set_msg(input string s);
        cur_msg.delete();
        for (int i = 0; i < s.len(); i++) cur_msg.push_back(s[i]);
    endtask

    // Pads cur_msg, pushes the first nblk expected blocks with their input chain
    // values, and optionally the expected digest.
    task automatic expect_msg(input int nblk, input bit push_dig, input bit use_const, input logic [255:0] dconst);
        logic [7:0]   p[$];
        logic [63:0]  len;
        logic [511:0] b;
        logic [255:0] h;
        blk_exp_t     e;
        p = cur_msg;
        len = 64'(cur_msg.size()) << 3;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(len[8*i +: 8]);
        h = IV;
        for (int k = 0; k < p.size() / 64; k++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b[511 - 8*j -: 8] = p[64*k + j];
            if (k < nblk) begin
                e.blk = b;
                e.chain = h;
                exp_blk_q.push_back(e);
            end
            h = sha_compress(h, b);
        end
        if (push_dig) exp_dig_q.push_back(use_const ? dconst : h);
    endtask

    task automatic send_msg();
        int waited;
        for (int i = 0; i < cur_msg.size(); i++) begin
            waited = 0;
            msg_valid = 1'b1;
            msg_data  = cur_msg[i];
            msg_last  = (i == cur_msg.size() - 1);
            while (msg_ready !== 1'b1 && waited < 2000) begin
                @(negedge clk);
                waited++;
            end
            if (msg_ready !== 1'b1) begin
                check("send_timeout", 512'(0), 512'(1));
                break;
            end
            @(negedge clk);
            if (i == 0) check("dv_clear", 512'(digest_valid), 512'(0));
        end
        msg_valid = 1'b0;
        msg_last  = 1'b0;
    endtask

    task automatic wait_digest();
        int waited;
        waited = 0;
        while (exp_dig_q.size() != 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (exp_dig_q.size() != 0) check("digest_timeout", 512'(0), 512'(1));
    endtask

    // Behavioural core: captures the block on start, answers after a short
    // latency and optionally holds done after start drops.
    int           mstate;
    int           mcnt;
    logic [255:0] mres;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            mstate    <= 0;
            mcnt      <= 0;
            mres      <= '0;
            done_in   <= 1'b0;
            result_in <= '0;
        end else begin
            case (mstate)
                0: if (start_out) begin
                    if (exp_blk_q.size() == 0) begin
                        check("blk_unexpected", 512'(1), 512'(0));
                    end else begin
                        check("blk_w", blk_w, exp_blk_q[0].blk);
                        check("chain_in", 512'(chain_out), 512'(exp_blk_q[0].chain));
                        void'(exp_blk_q.pop_front());
                    end
                    $display("block issued %h", blk_w[511:448]);
                    mres   <= sha_compress(chain_out, blk_w);
                    mcnt   <= 3;
                    mstate <= 1;
                end
                1: if (mcnt == 1) begin
                    done_in   <= 1'b1;
                    result_in <= mres;
                    mstate    <= 2;
                end else begin
                    mcnt <= mcnt - 1;
                end
                2: if (!start_out) begin
                    if (extra_hold == 0) begin
                        done_in <= 1'b0;
                        mstate  <= 0;
                    end else begin
                        mcnt   <= extra_hold;
                        mstate <= 3;
                    end
                end
                default: begin
                    check("rel_ready", 512'(msg_ready), 512'(0));
                    check("rel_start", 512'(start_out), 512'(0));
                    if (mcnt == 1) begin
                        done_in <= 1'b0;
                        mstate  <= 0;
                    end else begin
                        mcnt <= mcnt - 1;
                    end
                end
            endcase
        end
    end

    logic dv_prev;
    always @(negedge clk or posedge reset) begin
        if (reset) begin
            dv_prev <= 1'b0;
        end else begin
            dv_prev <= digest_valid;
            if (digest_valid && !dv_prev) begin
                if (exp_dig_q.size() == 0) begin
                    check("digest_unexpected", 512'(1), 512'(0));
                end else begin
                    check("digest", 512'(digest), 512'(exp_dig_q[0]));
                    void'(exp_dig_q.pop_front());
                end
                $display("digest %h", digest);
            end
        end
    end

    initial begin
        int waited;
        reset     = 1'b1;
        msg_valid = 1'b0;
        msg_data  = 8'h00;
        msg_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 512'(msg_ready), 512'(0));
        check("rst_start", 512'(start_out), 512'(0));
        check("rst_blk", blk_w, 512'(0));
        check("rst_chain", 512'(chain_out), 512'(IV));
        check("rst_digest", 512'(digest), 512'(0));
        check("rst_dv", 512'(digest_valid), 512'(0));
        reset = 1'b0;
        @(negedge clk);

        set_msg("abc");
        expect_msg(99, 1'b1, 1'b1, ABC_DIG);
        send_msg();
        wait_digest();

        set_msg("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        expect_msg(99, 1'b1, 1'b1, D56_DIG);
        send_msg();
        wait_digest();

        extra_hold = 5;
        cur_msg.delete();
        for (int i = 0; i < 64; i++) cur_msg.push_back(8'(i * 7 + 3));
        expect_msg(99, 1'b1, 1'b0, '0);
        send_msg();
        wait_digest();
        extra_hold = 0;

        // Abort during the first ISSUE of an "abc" message.
        set_msg("abc");
        expect_msg(1, 1'b0, 1'b0, '0);
        send_msg();
        waited = 0;
        while (start_out !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("issue_reached", 512'(start_out), 512'(1));
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_start", 512'(start_out), 512'(0));
        check("abort_chain", 512'(chain_out), 512'(IV));
        check("abort_dv", 512'(digest_valid), 512'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        set_msg("abc");
        expect_msg(99, 1'b1, 1'b1, ABC_DIG);
        send_msg();
        wait_digest();
        check("dv_held", 512'(digest_valid), 512'(1));
        set_msg("abc");
        expect_msg(99, 1'b1, 1'b1, ABC_DIG);
        send_msg();
        wait_digest();

        repeat (5) @(negedge clk);
        check("blk_queue_empty", 512'(exp_blk_q.size()), 512'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
